// File: rtl/phys_bus_master_pkg.sv
// Shared definitions for the MEM-stage Wishbone master: FSM state codes,
// the default bus timeout and the one-hot slave select codes shared with the TLB.
package phys_bus_master_pkg;

    typedef enum logic [1:0] {
        PBM_IDLE = 2'd0,
        PBM_BUSY = 2'd1,
        PBM_DONE = 2'd2
    } pbm_state_t;

    localparam int PBM_TIMEOUT = 255;

    // One-hot slave selects; the all-zero code means the address is unmapped
    localparam logic [15:0] WB_SELECT_RAM  = 16'h0001;
    localparam logic [15:0] WB_SELECT_ROM  = 16'h0002;
    localparam logic [15:0] WB_SELECT_UART = 16'h0004;

endpackage

// File: rtl/phys_bus_master_timeout_cnt.sv
// 8-bit BUSY-cycle counter with a terminal-count flag that marks the last
// cycle a slave is allowed before the master aborts the access.
module phys_bus_master_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // count_reg holds completed BUSY cycles, so this cycle is the TIMEOUT-th one
    assign tc = (count_reg == 8'(TIMEOUT - 1));

endmodule

// File: rtl/phys_bus_master.sv
// Wishbone classic single-cycle master behind the TLB: one access at a time,
// stalls the pipeline while busy and reports read data / bus error in DONE.
module phys_bus_master
    import phys_bus_master_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 16,
    parameter int TIMEOUT = PBM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [SEL_W-1:0]  cpu_slave,
    input  logic [3:0]        cpu_be,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_stall_i,
    input  logic              flush,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_bus_err,
    output logic              stall_req,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [DATA_W-1:0] wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_slave_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    pbm_state_t        state_reg, state_next;
    logic              cyc_reg, cyc_next;
    logic              we_reg, we_next;
    logic [DATA_W-1:0] adr_reg, adr_next;
    logic [3:0]        sel_reg, sel_next;
    logic [DATA_W-1:0] dat_reg, dat_next;
    logic [SEL_W-1:0]  slave_reg, slave_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic              cnt_clear, cnt_en, cnt_tc;

    phys_bus_master_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        we_next    = we_reg;
        adr_next   = adr_reg;
        sel_next   = sel_reg;
        dat_next   = dat_reg;
        slave_next = slave_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        stall_req  = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;

        case (state_reg)
            PBM_IDLE: begin
                stall_req = cpu_ce & ~flush;
                if (cpu_ce && !flush) begin
                    if (|cpu_slave) begin
                        we_next    = cpu_we;
                        adr_next   = cpu_addr;
                        sel_next   = cpu_be;
                        dat_next   = cpu_wdata;
                        slave_next = cpu_slave;
                        cyc_next   = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = PBM_BUSY;
                    end else begin
                        // Unmapped address: fail without touching the bus
                        rdata_next = '0;
                        err_next   = 1'b1;
                        state_next = PBM_DONE;
                    end
                end
            end
            PBM_BUSY: begin
                stall_req = 1'b1;
                cnt_en    = 1'b1;
                if (flush) begin
                    cyc_next   = 1'b0;
                    state_next = PBM_IDLE;
                end else if (wb_err_i) begin
                    cyc_next   = 1'b0;
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = PBM_DONE;
                end else if (wb_ack_i) begin
                    cyc_next   = 1'b0;
                    rdata_next = we_reg ? '0 : wb_dat_i;
                    err_next   = 1'b0;
                    state_next = PBM_DONE;
                end else if (cnt_tc) begin
                    cyc_next   = 1'b0;
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = PBM_DONE;
                end
            end
            PBM_DONE: begin
                // Results held until the pipeline actually advances past MEM
                if (!cpu_stall_i || flush) begin
                    err_next   = 1'b0;
                    state_next = PBM_IDLE;
                end
            end
            default: begin
                cyc_next   = 1'b0;
                state_next = PBM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= PBM_IDLE;
            cyc_reg   <= 1'b0;
            we_reg    <= 1'b0;
            adr_reg   <= '0;
            sel_reg   <= '0;
            dat_reg   <= '0;
            slave_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            we_reg    <= we_next;
            adr_reg   <= adr_next;
            sel_reg   <= sel_next;
            dat_reg   <= dat_next;
            slave_reg <= slave_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    assign wb_cyc_o    = cyc_reg;
    assign wb_stb_o    = cyc_reg;
    assign wb_we_o     = we_reg;
    assign wb_adr_o    = adr_reg;
    assign wb_sel_o    = sel_reg;
    assign wb_dat_o    = dat_reg;
    assign wb_slave_o  = slave_reg;
    assign cpu_rdata   = rdata_reg;
    assign cpu_bus_err = err_reg;

endmodule

// File: tb/tb_phys_bus_master.sv
// Directed bench for phys_bus_master: a transaction-level timeline model
// checked every cycle, plus hand-computed literal expectations per vector.
module tb_phys_bus_master;
    import phys_bus_master_pkg::*;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce, cpu_we, cpu_stall_i, flush;
    logic [31:0] cpu_addr, cpu_wdata, wb_dat_i;
    logic [15:0] cpu_slave;
    logic [3:0]  cpu_be;
    logic        wb_ack_i, wb_err_i;
    logic [31:0] cpu_rdata, wb_adr_o, wb_dat_o;
    logic        cpu_bus_err, stall_req, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [15:0] wb_slave_o;

    always #5 clk = ~clk;

    phys_bus_master dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce      (cpu_ce),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_slave   (cpu_slave),
        .cpu_be      (cpu_be),
        .cpu_wdata   (cpu_wdata),
        .cpu_stall_i (cpu_stall_i),
        .flush       (flush),
        .cpu_rdata   (cpu_rdata),
        .cpu_bus_err (cpu_bus_err),
        .stall_req   (stall_req),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_o    (wb_dat_o),
        .wb_slave_o  (wb_slave_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] slave;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        int          ack_at;    // BUSY-cycle index of ack, 0 = never
        int          err_at;
        int          flush_at;
        int          rst_at;
        int          hold;      // DONE cycles with cpu_stall_i held high
    } vec_t;

    typedef enum int {K_DONE, K_FLUSH, K_RST} kind_t;

    int n_vec  = 0;
    int n_miss = 0;
    int cur_id = -1;
    int cur_k  = 0;

    logic        chk_en = 1'b0;
    logic        e_cyc, e_stall, e_err, e_rd_valid, e_we;
    logic [31:0] e_rdata, e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [15:0] e_slave;

    logic        p_we;
    logic [31:0] p_adr, p_dat;
    logic [3:0]  p_sel;
    logic [15:0] p_slave;

    int          cyc_cnt, stall_cnt, exit_k;
    logic [31:0] exit_rd;
    logic        exit_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (vec %0d cycle %0d): got %h want %h", name, cur_id, cur_k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("wb_cyc_o",    32'(wb_cyc_o),    32'(e_cyc));
            check("wb_stb_o",    32'(wb_stb_o),    32'(e_cyc));
            check("stall_req",   32'(stall_req),   32'(e_stall));
            check("cpu_bus_err", 32'(cpu_bus_err), 32'(e_err));
            if (e_rd_valid) check("cpu_rdata", cpu_rdata, e_rdata);
            check("wb_we_o",    32'(wb_we_o),    32'(e_we));
            check("wb_adr_o",   wb_adr_o,        e_adr);
            check("wb_sel_o",   32'(wb_sel_o),   32'(e_sel));
            check("wb_dat_o",   wb_dat_o,        e_dat);
            check("wb_slave_o", 32'(wb_slave_o), 32'(e_slave));
            if (wb_cyc_o)  cyc_cnt++;
            if (stall_req) stall_cnt++;
            if (exit_k < 0 && cur_k >= 1 && !stall_req) begin
                exit_k   = cur_k;
                exit_rd  = cpu_rdata;
                exit_err = cpu_bus_err;
            end
        end
    end

    // Spec-level outcome: which event ends the access and in which BUSY cycle
    task automatic outcome(input vec_t v, output kind_t kind, output int b,
                           output logic err, output logic [31:0] rd);
        kind = K_DONE;
        b    = 0;
        err  = 1'b1;
        rd   = '0;
        if (v.slave == '0) return;
        b = TO;
        for (int k = 1; k <= TO; k++) begin
            if (v.flush_at == k) begin kind = K_FLUSH; b = k; return; end
            if (v.rst_at == k)   begin kind = K_RST;   b = k; return; end
            if (v.err_at == k)   begin b = k; return; end
            if (v.ack_at == k) begin
                b   = k;
                err = 1'b0;
                rd  = v.we ? 32'h0 : v.rdata_in;
                return;
            end
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        kind_t       kind;
        int          b, n, done_lo, done_hi;
        logic        err, in_done, busy;
        logic [31:0] rd;
        outcome(v, kind, b, err, rd);
        n       = (kind == K_DONE) ? b + v.hold + 3 : ((kind == K_FLUSH) ? b + 4 : b + 2);
        done_lo = b + 1;
        done_hi = b + 1 + v.hold;
        cur_id    = id;
        cyc_cnt   = 0;
        stall_cnt = 0;
        exit_k    = -1;
        for (int k = 0; k < n; k++) begin
            in_done     = (kind == K_DONE) && k >= done_lo && k <= done_hi;
            busy        = (v.slave != '0) && k >= 1 && k <= b;
            cpu_ce      = k <= ((kind == K_DONE) ? done_hi : b);
            cpu_we      = v.we;
            cpu_addr    = v.addr;
            cpu_slave   = v.slave;
            cpu_be      = v.be;
            cpu_wdata   = v.wdata;
            flush       = (kind == K_FLUSH) && k == b;
            rst         = (kind == K_RST) && k == b;
            cpu_stall_i = in_done && (k - done_lo) < v.hold;
            wb_ack_i    = v.ack_at > 0 && k == v.ack_at;
            wb_err_i    = v.err_at > 0 && k == v.err_at;
            wb_dat_i    = wb_ack_i ? v.rdata_in : (32'hA5A5_0000 | 32'(k));

            e_cyc      = busy;
            e_stall    = (k == 0) || busy;
            e_err      = in_done && err;
            e_rd_valid = in_done || ((kind == K_RST) && k == b + 1);
            e_rdata    = (kind == K_RST) ? 32'h0 : rd;
            if ((kind == K_RST) && k > b) begin
                e_we = 1'b0; e_adr = '0; e_sel = '0; e_dat = '0; e_slave = '0;
            end else if (v.slave != '0 && k >= 1) begin
                e_we = v.we; e_adr = v.addr; e_sel = v.be; e_dat = v.wdata; e_slave = v.slave;
            end else begin
                e_we = p_we; e_adr = p_adr; e_sel = p_sel; e_dat = p_dat; e_slave = p_slave;
            end
            cur_k  = k;
            chk_en = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
        if (kind == K_RST) begin
            p_we = 1'b0; p_adr = '0; p_sel = '0; p_dat = '0; p_slave = '0;
        end else if (v.slave != '0) begin
            p_we = v.we; p_adr = v.addr; p_sel = v.be; p_dat = v.wdata; p_slave = v.slave;
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [15:0] slave,
                                input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rdata_in,
                                input int ack_at, input int err_at, input int flush_at,
                                input int rst_at, input int hold);
        vec_t v;
        v.we = we; v.addr = addr; v.slave = slave; v.be = be; v.wdata = wdata;
        v.rdata_in = rdata_in; v.ack_at = ack_at; v.err_at = err_at;
        v.flush_at = flush_at; v.rst_at = rst_at; v.hold = hold;
        return v;
    endfunction

    vec_t vecs [11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1'b0, 32'h0000_0010, WB_SELECT_RAM,  4'hF,    32'h0,      32'hDEAD_BEEF, 2, 0, 0, 0, 0);
        vecs[1]  = mk(1'b1, 32'h1fd0_03f8, WB_SELECT_UART, 4'b0001, 32'h41,     32'h0,         1, 0, 0, 0, 0);
        vecs[2]  = mk(1'b0, 32'h8000_1000, 16'h0,          4'hF,    32'h0,      32'h0,         0, 0, 0, 0, 0);
        vecs[3]  = mk(1'b0, 32'h0000_0020, WB_SELECT_RAM,  4'hF,    32'h0,      32'h0,         0, 0, 0, 0, 0);
        vecs[4]  = mk(1'b1, 32'h0000_0024, WB_SELECT_RAM,  4'b0011, 32'hCAFE,   32'h0,         0, 3, 0, 0, 0);
        vecs[5]  = mk(1'b0, 32'h0000_0028, WB_SELECT_RAM,  4'hF,    32'h0,      32'h1111_1111, 4, 0, 2, 0, 0);
        vecs[6]  = mk(1'b0, 32'h0000_002c, WB_SELECT_RAM,  4'hF,    32'h0,      32'h1234_5678, 1, 0, 0, 0, 4);
        vecs[7]  = mk(1'b1, 32'h0000_0030, WB_SELECT_ROM,  4'b1100, 32'h55AA,   32'h0,         4, 0, 0, 2, 0);
        vecs[8]  = mk(1'b0, 32'h0000_0034, WB_SELECT_ROM,  4'hF,    32'h0,      32'h9999_9999, 1, 1, 0, 0, 0);
        vecs[9]  = mk(1'b0, 32'h0000_0038, WB_SELECT_RAM,  4'hF,    32'h0,      32'h7777_7777, 2, 0, 2, 0, 0);
        vecs[10] = mk(1'b1, 32'h0000_003c, WB_SELECT_UART, 4'b1000, 32'hAB00_0000, 32'hFFFF_FFFF, 2, 0, 0, 0, 1);

        rst = 1'b1; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_slave = '0;
        cpu_be = '0; cpu_wdata = '0; cpu_stall_i = 1'b0; flush = 1'b0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        p_we = 1'b0; p_adr = '0; p_sel = '0; p_dat = '0; p_slave = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset wb_cyc_o",    32'(wb_cyc_o),    32'h0);
        check("reset wb_stb_o",    32'(wb_stb_o),    32'h0);
        check("reset stall_req",   32'(stall_req),   32'h0);
        check("reset cpu_bus_err", 32'(cpu_bus_err), 32'h0);
        check("reset cpu_rdata",   cpu_rdata,        32'h0);
        check("reset wb_adr_o",    wb_adr_o,         32'h0);
        check("reset wb_slave_o",  32'(wb_slave_o),  32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
            $display("vec %0d: slave=%h we=%0d addr=%h cyc_cycles=%0d stall_cycles=%0d exit_cycle=%0d rdata=%h err=%0d",
                     i, vecs[i].slave, vecs[i].we, vecs[i].addr, cyc_cnt, stall_cnt, exit_k, exit_rd, exit_err);
            case (i)
                0: begin
                    check("v0 stall cycles", 32'(stall_cnt), 32'd3);
                    check("v0 exit cycle",   32'(exit_k),    32'd3);
                    check("v0 rdata",        exit_rd,        32'hDEAD_BEEF);
                    check("v0 bus_err",      32'(exit_err),  32'd0);
                end
                1: check("v1 cyc cycles", 32'(cyc_cnt), 32'd1);
                2: begin
                    check("v2 cyc cycles", 32'(cyc_cnt),  32'd0);
                    check("v2 exit cycle", 32'(exit_k),   32'd1);
                    check("v2 bus_err",    32'(exit_err), 32'd1);
                    check("v2 rdata",      exit_rd,       32'h0);
                end
                3: begin
                    check("v3 cyc cycles", 32'(cyc_cnt),  32'd255);
                    check("v3 bus_err",    32'(exit_err), 32'd1);
                end
                4: begin
                    check("v4 exit cycle", 32'(exit_k),   32'd4);
                    check("v4 bus_err",    32'(exit_err), 32'd1);
                end
                5: begin
                    check("v5 cyc cycles", 32'(cyc_cnt),  32'd2);
                    check("v5 bus_err",    32'(exit_err), 32'd0);
                end
                6: begin
                    check("v6 stall cycles", 32'(stall_cnt), 32'd2);
                    check("v6 rdata",        exit_rd,        32'h1234_5678);
                end
                10: check("v10 write rdata", exit_rd, 32'h0);
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
